// File: rtl/nfc_pause_detect.sv
// NFC reader pause detector: tracks the carrier envelope baseline and reports
// modulation pauses with hysteresis and a minimum run length on entry and exit.
module nfc_pause_detect #(
    parameter int DECAY_SHIFT  = 8,
    parameter int THRESH_SHIFT = 2,
    parameter int MIN_LEN      = 3
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        adc_data_en,
    input  logic [11:0] adc_data,
    output logic        pause,
    output logic        pause_start,
    output logic        pause_end,
    output logic [15:0] pause_len,
    output logic [11:0] baseline
);

    typedef enum logic [1:0] {
        ST_CARRIER,
        ST_ENTER,
        ST_PAUSE,
        ST_EXIT
    } state_t;

    localparam logic [7:0] MIN_CNT = 8'(MIN_LEN);

    state_t      state, state_nx;
    logic [7:0]  cnt, cnt_nx, cnt_inc;
    logic [15:0] len, len_nx, len_inc, len_exit;
    logic [16:0] exit_sum;
    logic [11:0] base_nx, low_th, high_th, decay_step, diff;
    logic        is_low, is_high;
    logic        pause_nx, start_nx, end_nx;
    logic [15:0] plen_nx;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= ST_CARRIER;
            cnt         <= 8'd0;
            len         <= 16'd0;
            baseline    <= 12'd0;
            pause       <= 1'b0;
            pause_start <= 1'b0;
            pause_end   <= 1'b0;
            pause_len   <= 16'd0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            len         <= len_nx;
            baseline    <= base_nx;
            pause       <= pause_nx;
            pause_start <= start_nx;
            pause_end   <= end_nx;
            pause_len   <= plen_nx;
        end
    end

    always_comb begin
        low_th     = baseline - (baseline >> THRESH_SHIFT);
        high_th    = baseline - (baseline >> (THRESH_SHIFT + 1));
        is_low     = adc_data < low_th;
        is_high    = adc_data >= high_th;
        decay_step = baseline >> DECAY_SHIFT;
        if (decay_step == 12'd0) begin
            decay_step = 12'd1;
        end
        diff     = baseline - adc_data;
        cnt_inc  = cnt + 8'd1;
        len_inc  = (len == 16'hFFFF) ? len : len + 16'd1;
        // The non-high sample that cancels an exit run also counts as pause.
        exit_sum = {1'b0, len} + {9'd0, cnt} + 17'd1;
        len_exit = exit_sum[16] ? 16'hFFFF : exit_sum[15:0];

        state_nx = state;
        cnt_nx   = cnt;
        len_nx   = len;
        base_nx  = baseline;
        start_nx = 1'b0;
        end_nx   = 1'b0;
        plen_nx  = pause_len;

        if (adc_data_en) begin
            case (state)
                ST_CARRIER: begin
                    if (adc_data > baseline) begin
                        base_nx = adc_data;
                    end else if (diff <= decay_step) begin
                        base_nx = adc_data;
                    end else begin
                        base_nx = baseline - decay_step;
                    end
                    if (is_low) begin
                        cnt_nx = 8'd1;
                        len_nx = 16'd1;
                        if (MIN_LEN == 1) begin
                            state_nx = ST_PAUSE;
                            start_nx = 1'b1;
                        end else begin
                            state_nx = ST_ENTER;
                        end
                    end
                end
                ST_ENTER: begin
                    if (is_low) begin
                        cnt_nx = cnt_inc;
                        len_nx = len_inc;
                        if (cnt_inc == MIN_CNT) begin
                            state_nx = ST_PAUSE;
                            start_nx = 1'b1;
                        end
                    end else begin
                        state_nx = ST_CARRIER;
                    end
                end
                ST_PAUSE: begin
                    if (is_high) begin
                        cnt_nx = 8'd1;
                        if (MIN_LEN == 1) begin
                            state_nx = ST_CARRIER;
                            end_nx   = 1'b1;
                            plen_nx  = len;
                        end else begin
                            state_nx = ST_EXIT;
                        end
                    end else begin
                        len_nx = len_inc;
                    end
                end
                ST_EXIT: begin
                    if (is_high) begin
                        cnt_nx = cnt_inc;
                        if (cnt_inc == MIN_CNT) begin
                            state_nx = ST_CARRIER;
                            end_nx   = 1'b1;
                            plen_nx  = len;
                        end
                    end else begin
                        state_nx = ST_PAUSE;
                        len_nx   = len_exit;
                    end
                end
                default: begin
                    state_nx = ST_CARRIER;
                end
            endcase
        end

        pause_nx = (state_nx == ST_PAUSE) || (state_nx == ST_EXIT);
    end

endmodule

// File: tb/tb_nfc_pause_detect.sv
// Self-checking bench for nfc_pause_detect: a run-length model of pause
// detection is compared every cycle, plus hand-computed scenario checks.
module tb_nfc_pause_detect;

    localparam int MIN_LEN = 3;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        adc_data_en = 1'b0;
    logic [11:0] adc_data = 12'd0;
    logic        pause, pause_start, pause_end;
    logic [15:0] pause_len;
    logic [11:0] baseline;

    int checks_total = 0;
    int checks_passed = 0;

    // Model state: baseline, whether inside a pause, current low run (before
    // the pause is confirmed), current high run (inside a pause), pause length.
    int  m_base = 0;
    bit  m_in_pause = 0;
    int  m_run = 0;
    int  m_hrun = 0;
    int  m_len = 0;
    int  m_plen = 0;
    bit  m_start = 0;
    bit  m_end = 0;

    nfc_pause_detect #(
        .DECAY_SHIFT (8),
        .THRESH_SHIFT(2),
        .MIN_LEN     (MIN_LEN)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .adc_data_en(adc_data_en),
        .adc_data   (adc_data),
        .pause      (pause),
        .pause_start(pause_start),
        .pause_end  (pause_end),
        .pause_len  (pause_len),
        .baseline   (baseline)
    );

    always #6 clk = ~clk;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_base = 0; m_in_pause = 0; m_run = 0; m_hrun = 0;
            m_len = 0; m_plen = 0; m_start = 0; m_end = 0;
        end else begin
            int s, low_th, high_th, step;
            m_start = 0;
            m_end = 0;
            if (adc_data_en) begin
                s = int'(adc_data);
                low_th  = m_base - m_base / 4;
                high_th = m_base - m_base / 8;
                if (!m_in_pause) begin
                    // Only a sample seen while purely on carrier moves the baseline.
                    if (m_run == 0) begin
                        step = (m_base / 256 > 0) ? m_base / 256 : 1;
                        if (s > m_base) m_base = s;
                        else m_base = (m_base - step > s) ? m_base - step : s;
                    end
                    if (s < low_th) begin
                        m_run++;
                        if (m_run == MIN_LEN) begin
                            m_in_pause = 1; m_start = 1;
                            m_len = m_run; m_run = 0; m_hrun = 0;
                        end
                    end else begin
                        m_run = 0;
                    end
                end else begin
                    if (s >= high_th) begin
                        m_hrun++;
                        if (m_hrun == MIN_LEN) begin
                            m_end = 1; m_plen = m_len;
                            m_in_pause = 0; m_run = 0; m_hrun = 0;
                        end
                    end else begin
                        m_len = m_len + m_hrun + 1;
                        if (m_len > 65535) m_len = 65535;
                        m_hrun = 0;
                    end
                end
            end
        end
    end

    task automatic check_output(input string name, input int actual, input int expected);
        checks_total++;
        if (actual == expected) checks_passed++;
        else $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    endtask

    always @(negedge clk) begin
        check_output("cyc_pause", int'(pause), int'(m_in_pause));
        check_output("cyc_pause_start", int'(pause_start), int'(m_start));
        check_output("cyc_pause_end", int'(pause_end), int'(m_end));
        check_output("cyc_pause_len", int'(pause_len), m_plen);
        check_output("cyc_baseline", int'(baseline), m_base);
    end

    task automatic feed(input int v, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            adc_data_en = 1'b1;
            adc_data = 12'(v);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        adc_data_en = 1'b0;
    endtask

    initial begin
        #2 rstn = 1'b0;
        #7;
        check_output("rst_pause", int'(pause), 0);
        check_output("rst_start", int'(pause_start), 0);
        check_output("rst_end", int'(pause_end), 0);
        check_output("rst_len", int'(pause_len), 0);
        check_output("rst_baseline", int'(baseline), 0);
        @(negedge clk);
        rstn = 1'b1;

        // Zero baseline: nothing counts as low.
        feed(0, 5); idle();
        check_output("zero_base_no_pause", int'(pause), 0);

        // Basic pause: 10 x 2000, 6 x 1000, 3+ x 2000.
        feed(2000, 1); idle();
        check_output("base_first_sample", int'(baseline), 2000);
        feed(2000, 9);
        feed(1000, 3); idle();
        check_output("start_after_3rd_low", int'(pause_start), 1);
        check_output("pause_level", int'(pause), 1);
        feed(1000, 3);
        feed(2000, 3); idle();
        check_output("end_after_3rd_high", int'(pause_end), 1);
        check_output("pause_len_6", int'(pause_len), 6);
        check_output("base_frozen_1993", int'(baseline), 1993);

        // Short glitch rejected.
        feed(2000, 2);
        feed(1000, 2);
        feed(2000, 3); idle();
        check_output("glitch_no_pause", int'(pause), 0);
        check_output("glitch_base", int'(baseline), 2000);
        check_output("glitch_len_kept", int'(pause_len), 6);

        // Hysteresis band and aborted exit run.
        feed(1000, 3);
        feed(1600, 10);
        feed(1000, 2);
        feed(2000, 2);
        feed(1000, 1); idle();
        check_output("hyst_still_pause", int'(pause), 1);
        feed(2000, 3); idle();
        check_output("hyst_end", int'(pause_end), 1);
        check_output("hyst_len_18", int'(pause_len), 18);

        // Baseline decay.
        feed(2000, 1);
        feed(1990, 1); idle();
        check_output("decay_1993", int'(baseline), 1993);
        feed(1990, 1); idle();
        check_output("decay_1990", int'(baseline), 1990);
        feed(1990, 3); idle();
        check_output("decay_hold_1990", int'(baseline), 1990);
        feed(1900, 1); idle();
        check_output("decay_1983", int'(baseline), 1983);
        feed(1900, 1); idle();
        check_output("decay_1976", int'(baseline), 1976);

        // Reset in the middle of a pause.
        feed(2000, 2);
        feed(1000, 4); idle();
        check_output("pre_reset_pause", int'(pause), 1);
        #3 rstn = 1'b0;
        #2;
        check_output("mid_rst_pause", int'(pause), 0);
        check_output("mid_rst_end", int'(pause_end), 0);
        check_output("mid_rst_baseline", int'(baseline), 0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        feed(2000, 1); idle();
        check_output("post_rst_base", int'(baseline), 2000);
        check_output("post_rst_no_end", int'(pause_end), 0);

        // Length saturation.
        feed(1000, 70000);
        feed(2000, 3); idle();
        check_output("sat_end", int'(pause_end), 1);
        check_output("sat_len", int'(pause_len), 65535);

        idle();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/nfc_pause_detect.md
NFC_PAUSE_DETECT -- requirements
Module: nfc_pause_detect

Interface
REQ-001 Parameter DECAY_SHIFT, default 8, sets the baseline decay step to baseline>>DECAY_SHIFT per sample.
REQ-002 Parameter THRESH_SHIFT, default 2, sets the pause-enter threshold to baseline - (baseline>>THRESH_SHIFT).
REQ-003 Parameter MIN_LEN, default 3, range 1..255, is the number of consecutive samples needed to enter or leave a pause.
REQ-004 Port rstn, input, 1 bit: asynchronous active-low reset.
REQ-005 Port clk, input, 1 bit: the single clock, 81.36 MHz.
REQ-006 Port adc_data_en, input, 1 bit: sample-valid strobe, one cycle per sample; back-to-back strobes are legal.
REQ-007 Port adc_data, input, 12 bits: unsigned ADC envelope sample, valid when adc_data_en=1.
REQ-008 Port pause, output, 1 bit: level output, 1 while the detected state is PAUSE or EXIT.
REQ-009 Port pause_start, output, 1 bit: one-cycle strobe on entry to PAUSE.
REQ-010 Port pause_end, output, 1 bit: one-cycle strobe on return to CARRIER from a pause.
REQ-011 Port pause_len, output, 16 bits: pause length in samples, updated with pause_end.
REQ-012 Port baseline, output, 12 bits: current carrier-amplitude estimate.

Function
REQ-013 All state updates shall occur only on cycles with adc_data_en=1; all outputs shall be registered and change in the cycle after the strobe (latency 1).
REQ-014 Thresholds shall be computed from the pre-update baseline B:
  - low_th = B - (B>>THRESH_SHIFT)
  - high_th = B - (B>>(THRESH_SHIFT+1))
  - "low" means sample < low_th; "high" means sample >= high_th.
REQ-015 In state CARRIER, baseline update per sample:
  - sample > B: B <= sample.
  - sample <= B: B <= max(sample, B - max(1, B>>DECAY_SHIFT)), i.e. no change when sample == B.
REQ-016 In states ENTER, PAUSE and EXIT, the baseline shall be frozen.
REQ-017 FSM states: CARRIER, ENTER, PAUSE, EXIT. cnt is an 8-bit counter; len is a 16-bit accumulator that saturates at 65535.
REQ-018 CARRIER transitions:
  - low sample: cnt=1, len=1; go to PAUSE if MIN_LEN==1, otherwise go to ENTER.
  - any other sample: stay in CARRIER.
REQ-019 ENTER transitions:
  - low sample: cnt++, len++; go to PAUSE when the new cnt == MIN_LEN.
  - non-low sample: return to CARRIER; no strobes (glitch rejected).
REQ-020 Every entry into PAUSE (from CARRIER or ENTER) shall assert pause_start for one cycle and set pause=1.
REQ-021 PAUSE transitions:
  - non-high sample: len++.
  - high sample: cnt=1; go to CARRIER if MIN_LEN==1 (apply REQ-023), otherwise go to EXIT.
REQ-022 EXIT transitions:
  - high sample: cnt++; when the new cnt == MIN_LEN, go to CARRIER (apply REQ-023).
  - non-high sample: return to PAUSE and add cnt+1 to len (the exit run is counted as pause).
REQ-023 On return to CARRIER from a pause:
  - pause_end pulses for one cycle, pause=0, pause_len <= len.
  - len excludes the high samples of the exit run.
REQ-024 Samples between threshold values (low_th <= sample < high_th) shall neither start nor end a pause (hysteresis).
REQ-025 Outside REQ-020 and REQ-023 events, pause_start and pause_end shall be 0; they shall never be 1 in the same cycle.
REQ-026 After reset (baseline 0, so low_th 0), no pause shall be detected until the baseline has risen.

Reset
REQ-027 Asserting rstn low shall immediately set:
  - state CARRIER, cnt=0, len=0, baseline=0;
  - pause=0, pause_start=0, pause_end=0, pause_len=0.
REQ-028 A reset during ENTER, PAUSE or EXIT shall abort the pause with no pause_end pulse; operation shall resume on the first strobe after rstn deasserts.

Verification (DECAY_SHIFT=8, THRESH_SHIFT=2, MIN_LEN=3; B=2000 gives low_th=1500, high_th=1750)
REQ-029 Scenario: 10 samples of 2000, then 6 of 1000, then 4 of 2000.
  - baseline=2000 after the first sample.
  - pause_start one cycle after the 3rd sample of 1000.
  - pause_end one cycle after the 3rd sample of 2000, with pause_len=6.
REQ-030 Scenario: baseline 2000, then 2 samples of 1000, then 2000s -> pause, pause_start and pause_end stay 0; baseline stays 2000.
REQ-031 Scenario: in PAUSE, 10 samples of 1600, then 1000s -> pause stays 1 with no pause_end; a 2000,2000,1000 sequence returns to PAUSE with len increased by 3.
REQ-032 Scenario: baseline 2000, then samples of 1990 -> baseline goes 1993, then 1990, and stays 1990; with sample 1900 it decays by 7 per sample.
REQ-033 Scenario: rstn pulsed low mid-PAUSE -> all outputs 0 asynchronously, with no pause_end; after release, 2000s rebuild baseline=2000.
REQ-034 Scenario: 70000 consecutive low samples, then 3 high samples -> pause_len=65535.
